// File: rtl/attex_bus_pkg.sv
`default_nettype none
// ============================================================================
// attex_bus_pkg : bus-cycle state type and region decode helper. Rev 1.0
// ============================================================================
package attex_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } bus_state_e;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;

   function automatic logic region_hit(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage
`default_nettype wire

// File: rtl/attex_bus_fabric_prio_enc.sv
`default_nettype none
// ============================================================================
// attex_prio_enc : lowest-index-wins one-hot and binary index encoder. Rev 1.0
// ============================================================================
module attex_prio_enc
   import attex_bus_pkg::*;
#(
   parameter int N     = 5,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] index,
   output logic             any
);

   // Walk from the top down so the lowest set bit is the last one written.
   always_comb begin
      onehot = '0;
      index  = '0;
      any    = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            index     = IDX_W'(i);
            any       = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/attex_bus_fabric.sv
`default_nettype none
// ============================================================================
// attex_bus_fabric : SCC68070 address decode, ack/data steering, watchdog. Rev 1.0
// ============================================================================
module attex_bus_fabric
   import attex_bus_pkg::*;
#(
   parameter int                       NUM_SLAVES     = 5,
   parameter logic [24*NUM_SLAVES-1:0] REGION_BASE    = {NUM_SLAVES{24'h0}},
   parameter logic [24*NUM_SLAVES-1:0] REGION_MASK    = {NUM_SLAVES{24'hff0000}},
   parameter int                       TIMEOUT_CYCLES = 1023,
   parameter bit                       UNMAPPED_ERR   = 1'b0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [23:1]                cpu_addr,
   input  logic                       cpu_as,
   input  logic                       cpu_uds,
   input  logic                       cpu_lds,
   input  logic                       cpu_write_strobe,
   output logic [15:0]                cpu_data_in,
   output logic                       cpu_bus_ack,
   output logic                       cpu_bus_err,
   input  logic [NUM_SLAVES-1:0]      iack_sel,
   output logic [NUM_SLAVES-1:0]      slave_cs,
   output logic [NUM_SLAVES-1:0]      slave_cs_rise,
   input  logic [NUM_SLAVES-1:0]      slave_ack,
   input  logic [16*NUM_SLAVES-1:0]   slave_dout,
   output logic [23:0]                err_addr,
   output logic                       err_timeout,
   output logic [7:0]                 err_count
);

   localparam int          IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [23:0]           byte_addr;
   logic [NUM_SLAVES-1:0] hit;
   logic [NUM_SLAVES-1:0] hit_oh;
   logic [NUM_SLAVES-1:0] iack_oh;
   logic [IDX_W-1:0]      hit_idx;
   logic [IDX_W-1:0]      iack_idx;
   logic                  hit_any;
   logic                  iack_any;
   logic [15:0]           dout_arr [NUM_SLAVES];
   logic                  ack_raw;
   logic                  expire;
   logic                  unmapped_err;
   logic                  unused_ok;

   bus_state_e            state_q, state_d;
   logic [15:0]           wdog_q, wdog_d;
   logic [NUM_SLAVES-1:0] slave_cs_q, slave_cs_d;
   logic [23:0]           err_addr_q, err_addr_d;
   logic                  err_timeout_q, err_timeout_d;
   logic [7:0]            err_count_q, err_count_d;

   assign byte_addr = {cpu_addr, 1'b0};

   for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slot
      assign hit[i]      = region_hit(byte_addr, REGION_BASE[24*i +: 24], REGION_MASK[24*i +: 24]);
      assign dout_arr[i] = slave_dout[16*i +: 16];
   end

   attex_prio_enc #(.N(NUM_SLAVES)) u_hit_enc (
      .req    (hit),
      .onehot (hit_oh),
      .index  (hit_idx),
      .any    (hit_any)
   );

   attex_prio_enc #(.N(NUM_SLAVES)) u_iack_enc (
      .req    (iack_sel),
      .onehot (iack_oh),
      .index  (iack_idx),
      .any    (iack_any)
   );

   assign slave_cs      = cpu_as ? hit_oh : '0;
   assign slave_cs_d    = slave_cs;
   assign slave_cs_rise = reset ? '0 : (slave_cs & ~slave_cs_q);

   always_comb begin
      cpu_data_in = 16'h0000;
      ack_raw     = 1'b0;
      if (iack_any) begin
         cpu_data_in = dout_arr[iack_idx];
         ack_raw     = 1'b1;
      end else if (hit_any) begin
         cpu_data_in = dout_arr[hit_idx];
         ack_raw     = slave_ack[hit_idx];
      end else begin
         ack_raw     = !UNMAPPED_ERR;
      end
   end

   assign cpu_bus_ack  = ack_raw && (state_q != ERR);
   assign cpu_bus_err  = (state_q == ERR);
   assign expire       = (wdog_q == TMO_LAST);
   assign unmapped_err = UNMAPPED_ERR && !hit_any;

   // Ack is tested before expiry so a late ack on the last watchdog cycle still completes.
   always_comb begin
      state_d       = state_q;
      wdog_d        = '0;
      err_addr_d    = err_addr_q;
      err_timeout_d = err_timeout_q;
      err_count_d   = err_count_q;
      case (state_q)
         IDLE: begin
            if (cpu_as && (cpu_uds || cpu_lds)) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (!cpu_as) begin
               state_d = IDLE;
            end else if (ack_raw) begin
               state_d = DONE;
            end else if (expire || unmapped_err) begin
               state_d       = ERR;
               err_addr_d    = byte_addr;
               err_timeout_d = !unmapped_err;
               if (err_count_q != 8'hff) err_count_d = err_count_q + 8'd1;
            end else begin
               wdog_d = wdog_q + 16'd1;
            end
         end
         DONE, ERR: begin
            if (!cpu_as) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         wdog_q        <= '0;
         slave_cs_q    <= '0;
         err_addr_q    <= '0;
         err_timeout_q <= 1'b0;
         err_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         wdog_q        <= wdog_d;
         slave_cs_q    <= slave_cs_d;
         err_addr_q    <= err_addr_d;
         err_timeout_q <= err_timeout_d;
         err_count_q   <= err_count_d;
      end
   end

   assign err_addr    = err_addr_q;
   assign err_timeout = err_timeout_q;
   assign err_count   = err_count_q;

   // Writes decode identically to reads; the iack one-hot is only needed as an index.
   assign unused_ok = ^{cpu_write_strobe, iack_oh};

endmodule
`default_nettype wire
